hawk_axird_arb: RTL and testbench

Shares the single AXI4 read-address/read-data port of the HAWK memory path between the page-read manager, decompression manager and compression manager. It arbitrates AR requests round-robin, issues one registered AR at a time, and records the owner of every outstanding read in an in-order route FIFO. It steers R beats back to the owning requester and supports an exclusive lock for the decompression burst sequence. It sits between the hawk managers and the AXI read FIFO / memory-controller port.

---
 rtl/hawk_axird_arb_pkg.sv | 43 ++++
 rtl/hawk_rd_route_fifo.sv | 66 ++++++
 rtl/hawk_axird_arb.sv | 192 +++++++++++++++++++
 tb/tb_hawk_axird_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_axird_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hawk_axird_arb_pkg
// Brief    : Shared types, requester indices and the round-robin pick helper
//            for the HAWK AXI read-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package hawk_axird_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ARB_IDLE         = 3'd0,
    ARB_ISSUE        = 3'd1,
    ARB_LOCKED_IDLE  = 3'd2,
    ARB_LOCKED_ISSUE = 3'd3,
    ARB_DRAIN_LOCK   = 3'd4
  } arb_state_e;

  localparam int RD_NUM_REQ = 3;
  // Widest request vector the pick helper understands
  localparam int RD_MAX_REQ = 8;

  // One route FIFO entry: the index of the requester owning a read
  typedef logic [$clog2(RD_NUM_REQ)-1:0] route_entry_t;

  localparam int RD_REQ_PGRD   = 0;
  localparam int RD_REQ_DECOMP = 1;
  localparam int RD_REQ_COMP   = 2;

  // Round-robin pick: first eligible index after 'last', wrapping at n.
  // Returns -1 when nothing is eligible.
  function automatic int rr_pick(input logic [RD_MAX_REQ-1:0] elig,
                                 input int n, input int last);
    int idx;
    rr_pick = -1;
    for (int k = 1; k <= RD_MAX_REQ; k++) begin
      idx = (last + k) % n;
      if (k <= n && rr_pick < 0 && elig[idx[2:0]]) rr_pick = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/hawk_rd_route_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hawk_rd_route_fifo
// Brief    : In-order FIFO holding the owner index of every outstanding read.
//            Simultaneous push and pop are both honoured.
// Revision : 1.0 - initial release
// ============================================================================
module hawk_rd_route_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr, rd;

  // Pointer and occupancy update; writes into a full FIFO and reads from an empty one are dropped
  always_comb begin
    wr       = push_i && !full_o;
    rd       = pop_i && !empty_o;
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr && !rd) cnt_d = cnt_q + 1'b1;
    else if (rd && !wr) cnt_d = cnt_q - 1'b1;
  end

  // Control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hawk_axird_arb.sv
`default_nettype none
// ============================================================================
// Module   : hawk_axird_arb
// Brief    : Round-robin arbiter sharing one AXI4 AR/R port between the HAWK
//            page-read, decompression and compression managers, with an
//            exclusive lock for the decompression burst sequence.
// Revision : 1.0 - initial release
// ============================================================================
module hawk_axird_arb
  import hawk_axird_arb_pkg::*;
#(
  parameter int NUM_REQ   = RD_NUM_REQ,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 4,
  parameter int LOCK_REQ  = RD_REQ_DECOMP
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_araddr_i,
  input  logic [NUM_REQ*8-1:0]        req_arlen_i,
  output logic [NUM_REQ-1:0]          req_arready_o,
  input  logic                        lock_i,
  output logic                        lock_gnt_o,
  output logic                        m_arvalid_o,
  output logic [ADDR_W-1:0]           m_araddr_o,
  output logic [7:0]                  m_arlen_o,
  input  logic                        m_arready_i,
  input  logic                        m_rvalid_i,
  input  logic [DATA_W-1:0]           m_rdata_i,
  input  logic [1:0]                  m_rresp_i,
  input  logic                        m_rlast_i,
  output logic                        m_rready_o,
  output logic [NUM_REQ-1:0]          req_rvalid_o,
  input  logic [NUM_REQ-1:0]          req_rready_i,
  output logic [DATA_W-1:0]           r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt_o,
  output logic                        err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic               m_arvalid_q, m_arvalid_d;
  logic [ADDR_W-1:0]  m_araddr_q, m_araddr_d;
  logic [7:0]         m_arlen_q, m_arlen_d;
  logic [IDX_W-1:0]   cur_q, cur_d, last_gnt_q, last_gnt_d;
  logic               lock_gnt_q, lock_gnt_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] elig, lock_mask;
  logic [IDX_W-1:0]   win, head;
  logic               found, do_grant, push, pop, rready_sel;
  logic               fifo_full, fifo_empty;
  int                 pick;

  // Arbitration FSM: pick a winner, hold the AR until accepted, manage the lock
  always_comb begin
    state_d       = state_q;
    m_arvalid_d   = m_arvalid_q;
    m_araddr_d    = m_araddr_q;
    m_arlen_d     = m_arlen_q;
    cur_d         = cur_q;
    last_gnt_d    = last_gnt_q;
    lock_gnt_d    = lock_gnt_q;
    req_arready_o = '0;
    push          = 1'b0;
    do_grant      = 1'b0;

    lock_mask           = '0;
    lock_mask[LOCK_REQ] = 1'b1;
    elig  = (state_q == ARB_LOCKED_IDLE) ? (req_arvalid_i & lock_mask) : req_arvalid_i;
    pick  = rr_pick(RD_MAX_REQ'(elig), NUM_REQ, int'(last_gnt_q));
    found = (pick >= 0);
    win   = pick[IDX_W-1:0];

    case (state_q)
      ARB_IDLE: begin
        if (lock_i) begin
          state_d = ARB_DRAIN_LOCK;
        end else if (!fifo_full && found) begin
          do_grant = 1'b1;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_LOCKED_IDLE: begin
        if (!lock_i) begin
          lock_gnt_d = 1'b0;
          state_d    = ARB_IDLE;
        end else if (!fifo_full && found) begin
          do_grant = 1'b1;
          state_d  = ARB_LOCKED_ISSUE;
        end
      end
      ARB_ISSUE, ARB_LOCKED_ISSUE: begin
        if (m_arready_i) begin
          m_arvalid_d = 1'b0;
          push        = 1'b1;
          last_gnt_d  = cur_q;
          state_d     = (state_q == ARB_ISSUE) ? ARB_IDLE : ARB_LOCKED_IDLE;
        end
      end
      ARB_DRAIN_LOCK: begin
        // No grants here, so every outstanding read belongs to a pre-lock owner
        if (outst_cnt_o == '0) begin
          lock_gnt_d = 1'b1;
          state_d    = ARB_LOCKED_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (do_grant) begin
      m_arvalid_d = 1'b1;
      cur_d       = win;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win == IDX_W'(i)) begin
          m_araddr_d       = req_araddr_i[i*ADDR_W +: ADDR_W];
          m_arlen_d        = req_arlen_i[i*8 +: 8];
          req_arready_o[i] = 1'b1;
        end
      end
    end
  end

  // R steering: FIFO head owns the beat; with no owner, drain and flag an error
  always_comb begin
    req_rvalid_o = '0;
    rready_sel   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!fifo_empty && head == IDX_W'(i)) begin
        req_rvalid_o[i] = m_rvalid_i;
        rready_sel      = req_rready_i[i];
      end
    end
    m_rready_o = fifo_empty ? m_rvalid_i : rready_sel;
    pop        = !fifo_empty && m_rvalid_i && m_rready_o && m_rlast_i;
    err_d      = err_q | (fifo_empty & m_rvalid_i);
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      cur_q       <= '0;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
      lock_gnt_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      cur_q       <= cur_d;
      last_gnt_q  <= last_gnt_d;
      lock_gnt_q  <= lock_gnt_d;
      err_q       <= err_d;
    end
  end

  hawk_rd_route_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (cur_q),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outst_cnt_o)
  );

  assign m_arvalid_o = m_arvalid_q;
  assign m_araddr_o  = m_araddr_q;
  assign m_arlen_o   = m_arlen_q;
  assign lock_gnt_o  = lock_gnt_q;
  assign err_o       = err_q;
  assign r_data_o    = m_rdata_i;
  assign r_resp_o    = m_rresp_i;
  assign r_last_o    = m_rlast_i;

endmodule
`default_nettype wire

// File: tb/tb_hawk_axird_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_hawk_axird_arb
// Brief    : Directed self-checking bench for hawk_axird_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hawk_axird_arb;

  localparam int NR = 3;
  localparam int AW = 64;
  localparam int DW = 512;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_arvalid;
  logic [NR*AW-1:0] req_araddr;
  logic [NR*8-1:0]  req_arlen;
  logic [NR-1:0]    req_arready;
  logic             lock, lock_gnt;
  logic             m_arvalid;
  logic [AW-1:0]    m_araddr;
  logic [7:0]       m_arlen;
  logic             m_arready;
  logic             m_rvalid;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;
  logic             m_rready;
  logic [NR-1:0]    req_rvalid;
  logic [NR-1:0]    req_rready;
  logic [DW-1:0]    r_data;
  logic [1:0]       r_resp;
  logic             r_last;
  logic [2:0]       outst;
  logic             err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hawk_axird_arb dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_arvalid_i (req_arvalid),
    .req_araddr_i  (req_araddr),
    .req_arlen_i   (req_arlen),
    .req_arready_o (req_arready),
    .lock_i        (lock),
    .lock_gnt_o    (lock_gnt),
    .m_arvalid_o   (m_arvalid),
    .m_araddr_o    (m_araddr),
    .m_arlen_o     (m_arlen),
    .m_arready_i   (m_arready),
    .m_rvalid_i    (m_rvalid),
    .m_rdata_i     (m_rdata),
    .m_rresp_i     (m_rresp),
    .m_rlast_i     (m_rlast),
    .m_rready_o    (m_rready),
    .req_rvalid_o  (req_rvalid),
    .req_rready_i  (req_rready),
    .r_data_o      (r_data),
    .r_resp_o      (r_resp),
    .r_last_o      (r_last),
    .outst_cnt_o   (outst),
    .err_o         (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [7:0] l);
    req_arvalid[i]          = v;
    req_araddr[i*AW +: AW]  = a;
    req_arlen[i*8 +: 8]     = l;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_arvalid = '0;
    lock        = 1'b0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    m_arready   = 1'b1;
    req_rready  = '1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req_araddr = '0;
    req_arlen  = '0;
    m_rdata    = '0;
    m_rresp    = 2'b00;
    do_reset();
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", m_arvalid); end
    total++; if (outst !== 3'd0) begin bad++; $display("FAIL reset_outst got=%0d exp=0", outst); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (lock_gnt !== 1'b0) begin bad++; $display("FAIL reset_lock_gnt got=%b exp=0", lock_gnt); end
    total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b exp=0", m_rready); end
    total++; if (req_rvalid !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", req_rvalid); end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = {16{32'hDEADBEEF}};
    set_req(0, 1'b1, 64'h1000, 8'd0);
    #1;
    total++; if (req_arready !== 3'b001) begin bad++; $display("FAIL single_arready got=%b exp=001", req_arready); end
    step();
    set_req(0, 1'b0, 64'h0, 8'd0);
    #1;
    total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid got=%b exp=1", m_arvalid); end
    total++; if (m_araddr !== 64'h1000) begin bad++; $display("FAIL single_araddr got=%h exp=1000", m_araddr); end
    step();
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL single_arvalid_clr got=%b exp=0", m_arvalid); end
    total++; if (outst !== 3'd1) begin bad++; $display("FAIL single_outst1 got=%0d exp=1", outst); end
    m_rdata = d; m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total++; if (req_rvalid !== 3'b001) begin bad++; $display("FAIL single_rvalid got=%b exp=001", req_rvalid); end
    total++; if (r_data !== d) begin bad++; $display("FAIL single_rdata got=%h exp=%h", r_data, d); end
    total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL single_rready got=%b exp=1", m_rready); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total++; if (outst !== 3'd0) begin bad++; $display("FAIL single_outst0 got=%0d exp=0", outst); end
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 2, 0};
    int exp_r[4] = '{1, 2, 0, 2};
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 64'(i + 1) << 8, (i == 2) ? 8'd3 : 8'd0);
    for (int g = 0; g < 4; g++) begin
      #1;
      total++; if (req_arready !== (3'b001 << exp_g[g])) begin bad++; $display("FAIL rr_grant%0d got=%b exp_idx=%0d", g, req_arready, exp_g[g]); end
      step();
      if (g == 3) req_arvalid = '0;
      #1;
      total++; if (m_araddr !== (64'(exp_g[g] + 1) << 8)) begin bad++; $display("FAIL rr_addr%0d got=%h exp_idx=%0d", g, m_araddr, exp_g[g]); end
      step();
    end
    #1;
    total++; if (outst !== 3'd4) begin bad++; $display("FAIL full_outst got=%0d exp=4", outst); end
    set_req(2, 1'b1, 64'hA000, 8'd3);
    #1;
    total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL full_nogrant got=%b exp=000", req_arready); end
    step();
    #1;
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL full_noissue got=%b exp=0", m_arvalid); end
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total++; if (req_rvalid !== 3'b001) begin bad++; $display("FAIL full_rvalid got=%b exp=001", req_rvalid); end
    total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL full_nogrant2 got=%b exp=000", req_arready); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total++; if (req_arready !== 3'b100) begin bad++; $display("FAIL full_refill got=%b exp=100", req_arready); end
    step();
    set_req(2, 1'b0, 64'h0, 8'd0);
    #1;
    total++; if (m_araddr !== 64'hA000) begin bad++; $display("FAIL full_addr got=%h exp=a000", m_araddr); end
    total++; if (m_arlen !== 8'd3) begin bad++; $display("FAIL full_arlen got=%0d exp=3", m_arlen); end
    step();
    // Non-last beat must not retire its read
    m_rvalid = 1'b1; m_rlast = 1'b0;
    #1;
    total++; if (req_rvalid !== 3'b010) begin bad++; $display("FAIL rr_midbeat got=%b exp=010", req_rvalid); end
    step();
    total++; if (outst !== 3'd4) begin bad++; $display("FAIL rr_midbeat_cnt got=%0d exp=4", outst); end
    for (int k = 0; k < 4; k++) begin
      m_rvalid = 1'b1; m_rlast = 1'b1;
      #1;
      total++; if (req_rvalid !== (3'b001 << exp_r[k])) begin bad++; $display("FAIL rr_route%0d got=%b exp_idx=%0d", k, req_rvalid, exp_r[k]); end
      step();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total++; if (outst !== 3'd0) begin bad++; $display("FAIL rr_drained got=%0d exp=0", outst); end
  endtask

  task automatic test_stall();
    int pulses;
    pulses = 0;
    m_arready = 1'b0;
    set_req(1, 1'b1, 64'hB000, 8'd0);
    #1;
    total++; if (req_arready !== 3'b010) begin bad++; $display("FAIL stall_grant got=%b exp=010", req_arready); end
    step();
    set_req(1, 1'b0, 64'h0, 8'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL stall_arvalid%0d got=%b exp=1", c, m_arvalid); end
      total++; if (m_araddr !== 64'hB000) begin bad++; $display("FAIL stall_addr%0d got=%h exp=b000", c, m_araddr); end
      if (req_arready !== 3'b000) pulses++;
      step();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL stall_pulses got=%0d exp=0", pulses); end
    m_arready = 1'b1;
    step();
    total++; if (outst !== 3'd1) begin bad++; $display("FAIL stall_outst got=%0d exp=1", outst); end
    req_rready = 3'b101; m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total++; if (req_rvalid !== 3'b010) begin bad++; $display("FAIL bp_rvalid got=%b exp=010", req_rvalid); end
    total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL bp_rready got=%b exp=0", m_rready); end
    step();
    total++; if (outst !== 3'd1) begin bad++; $display("FAIL bp_hold got=%0d exp=1", outst); end
    req_rready = 3'b111;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total++; if (outst !== 3'd0) begin bad++; $display("FAIL bp_done got=%0d exp=0", outst); end
  endtask

  task automatic test_lock();
    logic [AW-1:0] a;
    set_req(0, 1'b1, 64'h2000, 8'd0);
    step(); step(); step();
    set_req(0, 1'b0, 64'h0, 8'd0);
    step();
    #1;
    total++; if (outst !== 3'd2) begin bad++; $display("FAIL lock_pre_outst got=%0d exp=2", outst); end
    lock = 1'b1;
    set_req(0, 1'b1, 64'h3000, 8'd0);
    set_req(1, 1'b1, 64'h4000, 8'd0);
    set_req(2, 1'b1, 64'h5000, 8'd0);
    #1;
    total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL lock_enter_nogrant got=%b exp=000", req_arready); end
    step();
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total++; if (req_rvalid !== 3'b001) begin bad++; $display("FAIL lock_drain1 got=%b exp=001", req_rvalid); end
    step();
    #1;
    total++; if (lock_gnt !== 1'b0) begin bad++; $display("FAIL lock_early1 got=%b exp=0", lock_gnt); end
    total++; if (req_rvalid !== 3'b001) begin bad++; $display("FAIL lock_drain2 got=%b exp=001", req_rvalid); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total++; if (lock_gnt !== 1'b0) begin bad++; $display("FAIL lock_early2 got=%b exp=0", lock_gnt); end
    step();
    total++; if (lock_gnt !== 1'b1) begin bad++; $display("FAIL lock_gnt got=%b exp=1", lock_gnt); end
    for (int k = 0; k < 16; k++) begin
      a = 64'h4000 + 64'(k) * 64'h40;
      set_req(1, 1'b1, a, 8'd0);
      if (k > 0) begin m_rvalid = 1'b1; m_rlast = 1'b1; end
      #1;
      total++; if (req_arready !== 3'b010) begin bad++; $display("FAIL lock_grant%0d got=%b exp=010", k, req_arready); end
      if (k > 0) begin
        total++; if (req_rvalid !== 3'b010) begin bad++; $display("FAIL lock_route%0d got=%b exp=010", k, req_rvalid); end
      end
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      set_req(1, 1'b0, a, 8'd0);
      #1;
      total++; if (m_araddr !== a) begin bad++; $display("FAIL lock_addr%0d got=%h exp=%h", k, m_araddr, a); end
      step();
    end
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total++; if (req_rvalid !== 3'b010) begin bad++; $display("FAIL lock_last_route got=%b exp=010", req_rvalid); end
    total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL lock_blocked got=%b exp=000", req_arready); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    lock = 1'b0;
    #1;
    total++; if (req_arready !== 3'b000) begin bad++; $display("FAIL unlock_nogrant got=%b exp=000", req_arready); end
    step();
    total++; if (lock_gnt !== 1'b0) begin bad++; $display("FAIL unlock_gnt got=%b exp=0", lock_gnt); end
    total++; if (req_arready !== 3'b100) begin bad++; $display("FAIL unlock_grant got=%b exp=100", req_arready); end
    step();
    req_arvalid = '0;
    #1;
    total++; if (m_araddr !== 64'h5000) begin bad++; $display("FAIL unlock_addr got=%h exp=5000", m_araddr); end
    step();
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total++; if (req_rvalid !== 3'b100) begin bad++; $display("FAIL unlock_route got=%b exp=100", req_rvalid); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total++; if (outst !== 3'd0) begin bad++; $display("FAIL lock_end_outst got=%0d exp=0", outst); end
  endtask

  task automatic test_err();
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL err_rready got=%b exp=1", m_rready); end
    total++; if (req_rvalid !== 3'b000) begin bad++; $display("FAIL err_rvalid got=%b exp=000", req_rvalid); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    step(); step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_lock();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
